// File: rtl/any1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : any1_pkg
// Description : Shared types for the any1 pipeline: branch-resolution state
//               encoding and the machine address type.
// Revision    : 1.0 - initial release
// ============================================================================
package any1_pkg;

  // Machine address width used by the shared Address type.
  localparam int ANY1_AWID = 32;

  typedef logic [ANY1_AWID-1:0] Address;

  // Branch resolution states: accept slots, hold a redirect, drain execute.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } BrResState;

endpackage : any1_pkg
`default_nettype wire

// File: rtl/any1_br_stats.sv
`default_nettype none
// ============================================================================
// Module      : any1_br_stats
// Description : Free-running 32-bit counters of accepted branches and of
//               mispredictions. Counters wrap at 2^32.
// Ports       : clk_i, rst_i       - clock / synchronous active-high reset
//               br_inc, misp_inc   - one-cycle increment strobes
//               stat_br, stat_misp - registered counter values
// Revision    : 1.0 - initial release
// ============================================================================
module any1_br_stats
  import any1_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        br_inc,
  input  logic        misp_inc,
  output logic [31:0] stat_br,
  output logic [31:0] stat_misp
);

  logic [31:0] br_cnt_d, br_cnt_q;
  logic [31:0] misp_cnt_d, misp_cnt_q;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (br_inc)   br_cnt_d   = br_cnt_q + 32'd1;
    if (misp_inc) misp_cnt_d = misp_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q   <= 32'd0;
      misp_cnt_q <= 32'd0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign stat_br   = br_cnt_q;
  assign stat_misp = misp_cnt_q;

endmodule : any1_br_stats
`default_nettype wire

// File: rtl/any1_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : any1_branch_resolve
// Description : Branch resolution stage following the execute-stage branch
//               condition evaluator. Detects direction/target mispredictions,
//               raises a held fetch redirect with a one-cycle flush, stalls
//               execute for a fixed drain window, and emits a predictor
//               update pulse for every resolved branch.
// Config      : ANY1_BR_STATS_EN - when defined, adds stat_br / stat_misp
//               counter outputs (any1_br_stats instance).
// Ports       : clk_i, rst_i          - clock / synchronous active-high reset
//               ex_*                  - execute slot and prediction info
//               takb                  - evaluated branch outcome
//               ex_rdy                - stage can accept a slot (state decode)
//               redir_v/ip, redir_rdy - fetch redirect handshake
//               flush_o               - one-cycle younger-instruction flush
//               upd_v/ip/tk           - predictor update strobe and payload
//               stat_br, stat_misp    - counters (ANY1_BR_STATS_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module any1_branch_resolve
  import any1_pkg::*;
#(
  parameter int AWID         = 32,
  parameter int INSN_BYTES   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_v,
  input  logic            ex_is_br,
  input  logic [AWID-1:0] ex_ip,
  input  logic [AWID-1:0] ex_tgt,
  input  logic            ex_pred_tk,
  input  logic [AWID-1:0] ex_pred_tgt,
  input  logic            takb,
  output logic            ex_rdy,
  output logic            redir_v,
  output logic [AWID-1:0] redir_ip,
  input  logic            redir_rdy,
  output logic            flush_o,
  output logic            upd_v,
  output logic [AWID-1:0] upd_ip,
  output logic            upd_tk
`ifdef ANY1_BR_STATS_EN
  ,
  output logic [31:0]     stat_br,
  output logic [31:0]     stat_misp
`endif
);

  // Drain counter must hold FLUSH_CYCLES; keep at least one bit when it is 0.
  localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  BrResState       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [AWID-1:0] redir_ip_d, redir_ip_q;
  logic            flush_d, flush_q;
  logic            upd_v_d, upd_v_q;
  logic [AWID-1:0] upd_ip_d, upd_ip_q;
  logic            upd_tk_d, upd_tk_q;

  logic            accept;
  logic            misp;
  logic [AWID-1:0] fall_ip;
  logic [AWID-1:0] correct_ip;

  // Truncating add: the fall-through address wraps at 2^AWID.
  assign fall_ip    = ex_ip + AWID'(INSN_BYTES);
  assign correct_ip = takb ? ex_tgt : fall_ip;

  // Predicted target only matters when both prediction and outcome are taken.
  assign misp = (takb != ex_pred_tk) |
                (takb & ex_pred_tk & (ex_tgt != ex_pred_tgt));

  // ex_rdy is a pure state decode so upstream never sees a combinational
  // path from its own valid back to its ready.
  assign ex_rdy = (state_q == IDLE);
  assign accept = ex_v & ex_is_br & ex_rdy;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redir_ip_d = redir_ip_q;
    flush_d    = 1'b0;
    upd_v_d    = accept;
    upd_ip_d   = upd_ip_q;
    upd_tk_d   = upd_tk_q;

    if (accept) begin
      upd_ip_d = ex_ip;
      upd_tk_d = takb;
    end

    case (state_q)
      IDLE: begin
        if (accept && misp) begin
          state_d    = HOLD;
          redir_ip_d = correct_ip;
          // Registered so the flush lands in the first HOLD cycle only.
          flush_d    = 1'b1;
        end
      end
      HOLD: begin
        if (redir_rdy) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(FLUSH_CYCLES);
          end
        end
      end
      DRAIN: begin
        // Leave on the 1->0 step; a zero count also exits defensively.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      redir_ip_q <= '0;
      flush_q    <= 1'b0;
      upd_v_q    <= 1'b0;
      upd_ip_q   <= '0;
      upd_tk_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redir_ip_q <= redir_ip_d;
      flush_q    <= flush_d;
      upd_v_q    <= upd_v_d;
      upd_ip_q   <= upd_ip_d;
      upd_tk_q   <= upd_tk_d;
    end
  end

  assign redir_v  = (state_q == HOLD);
  assign redir_ip = redir_ip_q;
  assign flush_o  = flush_q;
  assign upd_v    = upd_v_q;
  assign upd_ip   = upd_ip_q;
  assign upd_tk   = upd_tk_q;

`ifdef ANY1_BR_STATS_EN
  any1_br_stats u_stats (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .br_inc    (accept),
    .misp_inc  (accept & misp),
    .stat_br   (stat_br),
    .stat_misp (stat_misp)
  );
`endif

endmodule : any1_branch_resolve
`default_nettype wire
